// File: rtl/equiv_miter_monitor_if.sv
// Output streams of the two implementations compared by equiv_miter_monitor.
// The harness drives through master; the monitor observes through slave.
interface equiv_miter_monitor_if #(
  parameter int WIDTH = 91
);
  logic             valid_a;
  logic [WIDTH-1:0] y_a;
  logic             valid_b;
  logic [WIDTH-1:0] y_b;

  modport master (output valid_a, y_a, valid_b, y_b);
  modport slave  (input  valid_a, y_a, valid_b, y_b);
endinterface

// File: rtl/equiv_miter_monitor.sv
// Equivalence monitor: skew-aligns two implementations, compares after warm-up, records first failure.
// Define EQUIV_ASSERT_EN to add an immediate assert that fires on every failing compare.

module equiv_miter_delay #(
  parameter int WIDTH = 91,
  parameter int DEPTH = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid,
  input  logic [WIDTH-1:0] data,
  output logic             valid_dly,
  output logic [WIDTH-1:0] data_dly
);
  if (DEPTH == 0) begin : g_pass
    logic unused_ok;
    assign unused_ok = clk ^ rst;
    assign valid_dly = valid;
    assign data_dly  = data;
  end else begin : g_line
    logic             v_q [DEPTH];
    logic [WIDTH-1:0] d_q [DEPTH];

    // Only the valid bits are reset; stale data behind a cleared valid is never compared.
    always_ff @(posedge clk) begin
      if (rst) begin
        for (int unsigned i = 0; i < DEPTH; i++) v_q[i] <= 1'b0;
      end else begin
        v_q[0] <= valid;
        for (int unsigned i = 1; i < DEPTH; i++) v_q[i] <= v_q[i-1];
      end
    end

    always_ff @(posedge clk) begin
      d_q[0] <= data;
      for (int unsigned i = 1; i < DEPTH; i++) d_q[i] <= d_q[i-1];
    end

    assign valid_dly = v_q[DEPTH-1];
    assign data_dly  = d_q[DEPTH-1];
  end
endmodule

module equiv_miter_monitor #(
  parameter int WIDTH        = 91,
  parameter int SKEW_A       = 0,
  parameter int SKEW_B       = 0,
  parameter int WARMUP       = 4,
  parameter int CNT_W        = 16,
  parameter int CYC_W        = 32,
  parameter int VALID_STRICT = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  equiv_miter_monitor_if.slave sides,
  output logic                 armed,
  output logic                 mismatch,
  output logic                 fail,
  output logic [CNT_W-1:0]     mism_cnt,
  output logic [CYC_W-1:0]     first_cyc,
  output logic [WIDTH-1:0]     first_diff
);
  localparam int WU_W = (WARMUP > 1) ? $clog2(WARMUP) : 1;
  localparam logic [WU_W-1:0] WU_LAST = WU_W'((WARMUP > 0) ? WARMUP - 1 : 0);

  typedef enum logic {WARM, ARMED} state_t;
  localparam state_t RST_STATE = (WARMUP == 0) ? ARMED : WARM;

  logic             va, vb;
  logic [WIDTH-1:0] da, db;

  equiv_miter_delay #(.WIDTH(WIDTH), .DEPTH(SKEW_A)) u_dly_a (
    .clk       (clk),
    .rst       (rst),
    .valid     (sides.valid_a),
    .data      (sides.y_a),
    .valid_dly (va),
    .data_dly  (da)
  );

  equiv_miter_delay #(.WIDTH(WIDTH), .DEPTH(SKEW_B)) u_dly_b (
    .clk       (clk),
    .rst       (rst),
    .valid     (sides.valid_b),
    .data      (sides.y_b),
    .valid_dly (vb),
    .data_dly  (db)
  );

  state_t          state_q, state_d;
  logic [WU_W-1:0] wu_q, wu_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RST_STATE;
      wu_q    <= '0;
    end else begin
      state_q <= state_d;
      wu_q    <= wu_d;
    end
  end

  always_comb begin
    state_d = state_q;
    wu_d    = wu_q;
    if (state_q == WARM && en) begin
      if (wu_q == WU_LAST) state_d = ARMED;
      else                 wu_d    = wu_q + WU_W'(1);
    end
  end

  assign armed = (state_q == ARMED);

  logic             cmp_ev;
  logic             cmp_fail;
  logic [WIDTH-1:0] cmp_diff;
  logic [CYC_W-1:0] cmp_idx;

  // Case inequality so X/Z on either side counts as a failure; diff keeps the 4-state XOR.
  always_comb begin
    cmp_ev   = 1'b0;
    cmp_fail = 1'b0;
    cmp_diff = '0;
    if (armed && en) begin
      if (va && vb) begin
        cmp_ev   = 1'b1;
        cmp_diff = da ^ db;
        cmp_fail = (da !== db);
      end else if (va ^ vb) begin
        if (VALID_STRICT != 0) begin
          cmp_ev   = 1'b1;
          cmp_fail = 1'b1;
          cmp_diff = '1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cmp_idx <= '0;
    end else if (cmp_ev && cmp_idx != '1) begin
      cmp_idx <= cmp_idx + CYC_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mismatch   <= 1'b0;
      fail       <= 1'b0;
      mism_cnt   <= '0;
      first_cyc  <= '0;
      first_diff <= '0;
    end else begin
      mismatch <= cmp_fail;
      if (cmp_fail) begin
        if (mism_cnt != '1) mism_cnt <= mism_cnt + CNT_W'(1);
        if (!fail) begin
          fail       <= 1'b1;
          first_cyc  <= cmp_idx;
          first_diff <= cmp_diff;
        end
      end
`ifdef EQUIV_ASSERT_EN
      assert (!cmp_fail)
        else $error("equiv_miter_monitor: mismatch at compare %0d diff %h", cmp_idx, cmp_diff);
`endif
    end
  end
endmodule

// File: tb/tb_equiv_miter_monitor.sv
// Scoreboard bench for equiv_miter_monitor: four configurations driven side by side.
module tb_equiv_miter_monitor;
  localparam int W  = 91;
  localparam int NU = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en  = 1'b1;
  always #5 clk = ~clk;

  equiv_miter_monitor_if #(.WIDTH(W)) if0 ();
  equiv_miter_monitor_if #(.WIDTH(W)) if1 ();
  equiv_miter_monitor_if #(.WIDTH(W)) if2 ();
  equiv_miter_monitor_if #(.WIDTH(W)) if3 ();

  logic         arm [NU];
  logic         mis [NU];
  logic         fl  [NU];
  logic [15:0]  cnt [NU];
  logic [3:0]   cnt3;
  logic [31:0]  fc  [NU];
  logic [W-1:0] fd  [NU];
  assign cnt[3] = {12'd0, cnt3};

  // u0: baseline strict; u1: A skewed by 2; u2: non-strict valid; u3: 4-bit counter
  equiv_miter_monitor #(.WIDTH(W), .SKEW_A(0), .SKEW_B(0), .WARMUP(4), .CNT_W(16), .CYC_W(32), .VALID_STRICT(1)) u0 (
    .clk(clk), .rst(rst), .en(en), .sides(if0.slave), .armed(arm[0]), .mismatch(mis[0]),
    .fail(fl[0]), .mism_cnt(cnt[0]), .first_cyc(fc[0]), .first_diff(fd[0]));
  equiv_miter_monitor #(.WIDTH(W), .SKEW_A(2), .SKEW_B(0), .WARMUP(4), .CNT_W(16), .CYC_W(32), .VALID_STRICT(1)) u1 (
    .clk(clk), .rst(rst), .en(en), .sides(if1.slave), .armed(arm[1]), .mismatch(mis[1]),
    .fail(fl[1]), .mism_cnt(cnt[1]), .first_cyc(fc[1]), .first_diff(fd[1]));
  equiv_miter_monitor #(.WIDTH(W), .SKEW_A(0), .SKEW_B(0), .WARMUP(4), .CNT_W(16), .CYC_W(32), .VALID_STRICT(0)) u2 (
    .clk(clk), .rst(rst), .en(en), .sides(if2.slave), .armed(arm[2]), .mismatch(mis[2]),
    .fail(fl[2]), .mism_cnt(cnt[2]), .first_cyc(fc[2]), .first_diff(fd[2]));
  equiv_miter_monitor #(.WIDTH(W), .SKEW_A(0), .SKEW_B(0), .WARMUP(4), .CNT_W(4), .CYC_W(32), .VALID_STRICT(1)) u3 (
    .clk(clk), .rst(rst), .en(en), .sides(if3.slave), .armed(arm[3]), .mismatch(mis[3]),
    .fail(fl[3]), .mism_cnt(cnt3), .first_cyc(fc[3]), .first_diff(fd[3]));

  typedef struct {
    int unsigned  unit;
    logic [W-1:0] diff;
    int unsigned  idx;
    int unsigned  cnt;
    bit           first;
  } exp_t;

  exp_t         sb [$];
  int unsigned  n_cmp = 0;
  int unsigned  n_bad = 0;
  int unsigned  exp_cnt [NU];
  bit           exp_fail [NU];
  int unsigned  pulses [NU];
  int unsigned  idx0, idx2, idx3;
  bit           armed_exp;
  logic [W-1:0] h0, h1;
  logic         hv0, hv1;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int unsigned cnt_max(input int unsigned u);
    return (u == 3) ? 15 : 65535;
  endfunction

  function automatic logic [W-1:0] rnd();
    logic [95:0] t;
    t = {$urandom(), $urandom(), $urandom()};
    return t[W-1:0];
  endfunction

  task automatic push_exp(input int unsigned u, input logic [W-1:0] diff, input int unsigned idx);
    exp_t e;
    if (exp_cnt[u] < cnt_max(u)) exp_cnt[u]++;
    e.unit  = u;
    e.diff  = diff;
    e.idx   = idx;
    e.cnt   = exp_cnt[u];
    e.first = !exp_fail[u];
    exp_fail[u] = 1'b1;
    sb.push_back(e);
  endtask

  // One clock of stimulus; expected failures are queued before the compare edge.
  task automatic step(input logic [W-1:0] f0, input logic [W-1:0] f1, input logic [W-1:0] f2,
                      input logic [W-1:0] f3, input logic vb0, input logic vb2);
    logic [W-1:0] r;
    r = rnd();
    if0.valid_a = 1'b1; if0.y_a = r ^ f0; if0.valid_b = vb0;  if0.y_b = r;
    if1.valid_a = 1'b1; if1.y_a = r ^ f1; if1.valid_b = hv1;  if1.y_b = h1;
    if2.valid_a = 1'b1; if2.y_a = r ^ f2; if2.valid_b = vb2;  if2.y_b = r;
    if3.valid_a = 1'b1; if3.y_a = r ^ f3; if3.valid_b = 1'b1; if3.y_b = r;
    h1 = h0; hv1 = hv0; h0 = r; hv0 = 1'b1;
    if (armed_exp && en) begin
      if (!vb0) push_exp(0, '1, idx0);
      else if (f0 != '0) push_exp(0, f0, idx0);
      idx0++;
      if (vb2) begin
        if (f2 != '0) push_exp(2, f2, idx2);
        idx2++;
      end
      if (f3 != '0) push_exp(3, f3, idx3);
      idx3++;
    end
    @(posedge clk); #1;
  endtask

  task automatic clean(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) step('0, '0, '0, '0, 1'b1, 1'b1);
  endtask

  task automatic drain();
    clean(2);
    check_eq("scoreboard_drained", 128'(sb.size()), 128'(0));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    if0.valid_a = 1'b0; if0.valid_b = 1'b0;
    if1.valid_a = 1'b0; if1.valid_b = 1'b0;
    if2.valid_a = 1'b0; if2.valid_b = 1'b0;
    if3.valid_a = 1'b0; if3.valid_b = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    hv0 = 1'b0; hv1 = 1'b0;
    armed_exp = 1'b0;
    idx0 = 0; idx2 = 0; idx3 = 0;
    sb.delete();
    for (int unsigned u = 0; u < NU; u++) begin
      exp_cnt[u] = 0; exp_fail[u] = 1'b0; pulses[u] = 0;
      check_eq($sformatf("u%0d_rst_armed", u),    128'(arm[u]), 128'(0));
      check_eq($sformatf("u%0d_rst_mismatch", u), 128'(mis[u]), 128'(0));
      check_eq($sformatf("u%0d_rst_fail", u),     128'(fl[u]),  128'(0));
      check_eq($sformatf("u%0d_rst_cnt", u),      128'(cnt[u]), 128'(0));
      check_eq($sformatf("u%0d_rst_first_cyc", u),  128'(fc[u]), 128'(0));
      check_eq($sformatf("u%0d_rst_first_diff", u), 128'(fd[u]), 128'(0));
    end
  endtask

  // en=0 cycles are inserted after `gap_at` enabled cycles; armed must follow the 4th enabled one.
  task automatic warm(input int unsigned gap_at, input int unsigned gap_len);
    for (int unsigned k = 1; k <= 4; k++) begin
      clean(1);
      check_eq("u0_armed_warmup", 128'(arm[0]), 128'(k == 4));
      if (k == gap_at) begin
        en = 1'b0;
        for (int unsigned g = 0; g < gap_len; g++) begin
          clean(1);
          check_eq("u0_armed_en_low", 128'(arm[0]), 128'(0));
        end
        en = 1'b1;
      end
    end
    for (int unsigned u = 1; u < NU; u++)
      check_eq($sformatf("u%0d_armed", u), 128'(arm[u]), 128'(1));
    armed_exp = 1'b1;
  endtask

  int   mk;
  exp_t me;
  always @(negedge clk) begin
    for (int unsigned u = 0; u < NU; u++) begin
      if (!rst && mis[u] === 1'b1) begin
        pulses[u]++;
        mk = -1;
        foreach (sb[i]) if (mk < 0 && sb[i].unit == u) mk = i;
        if (mk < 0) begin
          check_eq($sformatf("u%0d_unexpected_pulse", u), 128'(mis[u]), 128'(0));
        end else begin
          me = sb[mk];
          sb.delete(mk);
          check_eq($sformatf("u%0d_mism_cnt", u), 128'(cnt[u]), 128'(me.cnt));
          check_eq($sformatf("u%0d_fail", u),     128'(fl[u]),  128'(1));
          if (me.first) begin
            check_eq($sformatf("u%0d_first_cyc", u),  128'(fc[u]), 128'(me.idx));
            check_eq($sformatf("u%0d_first_diff", u), 128'(fd[u]), 128'(me.diff));
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] f0, f3;
    h0 = '0; h1 = '0; hv0 = 1'b0; hv1 = 1'b0;
    armed_exp = 1'b0;

    // Identical streams, plus u1 fed with B = A delayed by two cycles
    do_reset();
    warm(0, 0);
    for (int unsigned i = 0; i < 200; i++) begin
      clean(1);
      if (i == 99) begin
        check_eq("u0_fail_after_100", 128'(fl[0]),  128'(0));
        check_eq("u0_cnt_after_100",  128'(cnt[0]), 128'(0));
      end
    end
    drain();
    for (int unsigned u = 0; u < NU; u++) begin
      check_eq($sformatf("u%0d_clean_fail", u), 128'(fl[u]),  128'(0));
      check_eq($sformatf("u%0d_clean_cnt", u),  128'(cnt[u]), 128'(0));
    end

    // u0: faults at compare 10 and 20; u3: 20 consecutive failing compares
    do_reset();
    warm(0, 0);
    for (int unsigned i = 0; i < 30; i++) begin
      f0 = (idx0 == 10) ? (W'(1) << 5) : (idx0 == 20) ? W'(1) : '0;
      f3 = (idx3 < 20) ? (W'(1) << $urandom_range(W - 1, 0)) : '0;
      step(f0, '0, '0, f3, 1'b1, 1'b1);
    end
    drain();
    check_eq("u0_pulses",     128'(pulses[0]), 128'(2));
    check_eq("u0_cnt_final",  128'(cnt[0]),    128'(2));
    check_eq("u0_first_cyc",  128'(fc[0]),     128'(10));
    check_eq("u0_first_diff", 128'(fd[0]),     128'(W'(1) << 5));
    check_eq("u0_fail_final", 128'(fl[0]),     128'(1));
    check_eq("u3_pulses",     128'(pulses[3]), 128'(20));
    check_eq("u3_cnt_sat",    128'(cnt[3]),    128'(15));
    check_eq("u3_fail_final", 128'(fl[3]),     128'(1));

    // A bad A-side sample left in u1's delay line must be discarded by reset
    step('0, W'(1) << 7, '0, '0, 1'b1, 1'b1);
    do_reset();
    warm(2, 3);

    // Valid disagreement: strict u0 fails with all-ones diff; u2 skips without advancing its index
    clean(3);
    step('0, '0, '0, '0, 1'b0, 1'b0);
    clean(2);
    step('0, '0, W'(1) << 3, '0, 1'b1, 1'b1);
    en = 1'b0;
    step(W'(1) << 2, '0, '0, '0, 1'b1, 1'b1);
    en = 1'b1;
    drain();
    check_eq("u0_valid_pulses", 128'(pulses[0]), 128'(1));
    check_eq("u2_valid_pulses", 128'(pulses[2]), 128'(1));
    check_eq("u2_first_cyc_idx", 128'(fc[2]),    128'(5));
    check_eq("u1_stale_fail",   128'(fl[1]),     128'(0));
    check_eq("u1_stale_cnt",    128'(cnt[1]),    128'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
